seg_scan_ctrl: RTL and testbench
================================

Name: seg_scan_ctrl

Overview:
- Time-multiplexed scan controller for the 4-digit seven-segment display (seg/an/dp) on the top-level board.
- Game logic posts a 16-bit hex value plus decimal-point mask with a single-cycle load.
- The block double-buffers the value and commits it only at a frame boundary, so no digit ever tears mid-scan.
- It inserts a blanking interval between digits to suppress ghosting.

Parameters:
- CLK_DIV, 50000: drive cycles per digit slot; must be >= 1.
- BLANK_CYC, 16: blank cycles before each digit's drive window; must be >= 1.

Ports:
- clk  in  1  system clock (50 MHz)
- clr  in  1  reset; asynchronous, active-high
- load  in  1  single-cycle strobe; captures value/dp_in
- value  in  16  four hex nibbles; [3:0] is the rightmost digit (an[0])
- dp_in  in  4  decimal-point enables, bit i belongs to digit i
- seg  out  7  segment cathodes, active-low; seg[0]=a … seg[6]=g
- an  out  4  digit anodes, active-low, at most one low
- dp  out  1  decimal point, active-low
- pending  out  1  shadow holds an uncommitted value
- frame_start  out  1  one-cycle pulse on each commit/wrap edge

Behaviour:
- Reset (clr high, async): state=BLANK, digit=0, counter=0, shadow=0, active=0, pending=0. Outputs: an=4'b1111, seg=7'b1111111, dp=1, frame_start=0.
- Outputs are decoded only from registered state. There is no combinational path from any input to any output.
- FSM has two states:
  - BLANK: an=1111, seg=1111111, dp=1. Stay for BLANK_CYC cycles, then go to DRIVE.
  - DRIVE: an[digit]=0, seg=hex decode of active[4*digit+:4], dp=~active_dp[digit]. Stay for CLK_DIV cycles, then go to BLANK with digit=digit+1 mod 4.
- Digit slot = BLANK_CYC+CLK_DIV cycles. Frame = 4 slots.
- Wrap edge: the DRIVE->BLANK transition where digit goes 3->0.
  - frame_start=1 for exactly the cycle after that edge.
  - If pending=1, shadow is copied to active on that edge and pending clears.
- load=1: shadow/shadow_dp <= value/dp_in and pending <= 1. The last load before the wrap edge wins.
- load coinciding with the wrap edge: the incoming value bypasses the shadow and is written directly to active; pending=0 afterwards.
- Decode table (seg, active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Counter width is $clog2(max(CLK_DIV,BLANK_CYC)+1). It reloads to 0 on every state change and never free-wraps.
- clr asserted mid-frame immediately returns to the reset state; the first drive window after release is digit 0 showing 0.

Optional Feature:
- Macro: SEG_LZ_BLANK_EN.
- Defined: leading-zero suppression. During DRIVE of digit i (i=3..1), the anode stays high if active nibbles i..3 are all zero and active_dp[i]=0. Digit 0 is always driven.
- Not defined: all four digits are always driven.

Test Plan:
- CLK_DIV=8, BLANK_CYC=2, release clr -> an=1111 for 2 cycles, then an=1110 with seg=1000000 for 8 cycles. Pattern repeats for 1101/1011/0111 with period 40; frame_start pulses every 40 cycles.
- load value=16'h12AF, dp_in=4'b0100 mid-frame -> pending=1 and the current frame is unchanged. After the next wrap: digit0 seg=0001110, digit1 0001000, digit2 0100100 with dp=0, digit3 1111001; pending=0.
- Two loads (16'h1111 then 16'h2222) in one frame -> only 2222 is displayed after the wrap; 1111 never appears.
- load 16'h0005 on the exact wrap edge -> next digit0 window shows seg=0010010; pending stays 0.
- clr pulsed during a digit-2 drive window -> an=1111 and seg=1111111 asynchronously; after release, active=0000 and the scan restarts at digit 0.
- SEG_LZ_BLANK_EN defined, value=16'h0070 -> digits 3 and 2 keep an high during their windows; digit1 shows 1111000 and digit0 shows 1000000.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// Four-digit seven-segment scan controller with frame-aligned double buffering.
// Optional leading-zero suppression is enabled by defining SEG_LZ_BLANK_EN.
module seg_scan_ctrl #(
    parameter int CLK_DIV   = 50000,
    parameter int BLANK_CYC = 16
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        load,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        dp,
    output logic        pending,
    output logic        frame_start
);

    localparam int MAX_CYC = (CLK_DIV > BLANK_CYC) ? CLK_DIV : BLANK_CYC;
    localparam int CW      = $clog2(MAX_CYC + 1);

    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
    localparam logic [CW-1:0] DRIVE_LAST = CW'(CLK_DIV - 1);

    localparam logic [0:0] ST_BLANK = 1'b0;
    localparam logic [0:0] ST_DRIVE = 1'b1;

    logic [0:0]    state_q,       state_d;
    logic [1:0]    digit_q,       digit_d;
    logic [CW-1:0] cnt_q,         cnt_d;
    logic [15:0]   shadow_q,      shadow_d;
    logic [3:0]    shadow_dp_q,   shadow_dp_d;
    logic [15:0]   active_q,      active_d;
    logic [3:0]    active_dp_q,   active_dp_d;
    logic          pending_q,     pending_d;
    logic          frame_start_q, frame_start_d;

    logic          wrap;
    logic          lz_blank;
    logic [3:0]    nibble;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    assign wrap = (state_q == ST_DRIVE) && (cnt_q == DRIVE_LAST) && (digit_q == 2'd3);

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path infers a latch.
        state_d       = state_q;
        digit_d       = digit_q;
        cnt_d         = cnt_q + CW'(1);
        shadow_d      = shadow_q;
        shadow_dp_d   = shadow_dp_q;
        active_d      = active_q;
        active_dp_d   = active_dp_q;
        pending_d     = pending_q;
        frame_start_d = wrap;

        case (state_q)
            ST_BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d = ST_DRIVE;
                    cnt_d   = '0;
                end
            end
            default: begin
                if (cnt_q == DRIVE_LAST) begin
                    state_d = ST_BLANK;
                    cnt_d   = '0;
                    digit_d = digit_q + 2'd1;
                end
            end
        endcase

        // A load on the wrap edge goes straight to the active buffer.
        if (wrap && load) begin
            active_d    = value;
            active_dp_d = dp_in;
            pending_d   = 1'b0;
        end else if (wrap && pending_q) begin
            active_d    = shadow_q;
            active_dp_d = shadow_dp_q;
            pending_d   = 1'b0;
        end else if (load) begin
            shadow_d    = value;
            shadow_dp_d = dp_in;
            pending_d   = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q       <= ST_BLANK;
            digit_q       <= 2'd0;
            cnt_q         <= '0;
            shadow_q      <= '0;
            shadow_dp_q   <= '0;
            active_q      <= '0;
            active_dp_q   <= '0;
            pending_q     <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            digit_q       <= digit_d;
            cnt_q         <= cnt_d;
            shadow_q      <= shadow_d;
            shadow_dp_q   <= shadow_dp_d;
            active_q      <= active_d;
            active_dp_q   <= active_dp_d;
            pending_q     <= pending_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign nibble = active_q[4*digit_q +: 4];

`ifdef SEG_LZ_BLANK_EN
    always_comb begin
        case (digit_q)
            2'd3:    lz_blank = (active_q[15:12] == 4'h0)  && !active_dp_q[3];
            2'd2:    lz_blank = (active_q[15:8]  == 8'h00) && !active_dp_q[2];
            2'd1:    lz_blank = (active_q[15:4]  == 12'h0) && !active_dp_q[1];
            default: lz_blank = 1'b0;
        endcase
    end
`else
    assign lz_blank = 1'b0;
`endif

    // Outputs depend only on registered state; no input reaches them combinationally.
    always_comb begin
        an  = 4'b1111;
        seg = 7'b1111111;
        dp  = 1'b1;
        if (state_q == ST_DRIVE && !lz_blank) begin
            an  = ~(4'b0001 << digit_q);
            seg = hex_to_seg(nibble);
            dp  = ~active_dp_q[digit_q];
        end
    end

    assign pending     = pending_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: table-driven loads with a scoreboard of
// expected digit windows, plus hand-written wrap-edge, double-load and clear sequences.
module tb_seg_scan_ctrl;

    localparam int CLK_DIV   = 8;
    localparam int BLANK_CYC = 2;
    localparam int SLOT      = CLK_DIV + BLANK_CYC;
    localparam int FRAME     = 4 * SLOT;
`ifdef SEG_LZ_BLANK_EN
    localparam bit LZ_EN = 1'b1;
`else
    localparam bit LZ_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        clr;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        dp;
    logic        pending;
    logic        frame_start;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    typedef struct {
        logic [15:0] value;
        logic [3:0]  dp;
    } vec_t;

    exp_t        sb_q[$];
    vec_t        vecs[6];
    logic [6:0]  seg_ref[16];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic        mon_en   = 1'b0;
    logic [3:0]  an_prev  = 4'hF;
    logic [15:0] cur_val;
    logic [3:0]  cur_dp;

    seg_scan_ctrl #(
        .CLK_DIV   (CLK_DIV),
        .BLANK_CYC (BLANK_CYC)
    ) dut (
        .clk         (clk),
        .clr         (clr),
        .load        (load),
        .value       (value),
        .dp_in       (dp_in),
        .seg         (seg),
        .an          (an),
        .dp          (dp),
        .pending     (pending),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic digit_blanked(input logic [15:0] v, input logic [3:0] d, input int i);
        return LZ_EN && (i > 0) && ((v >> (4 * i)) == 16'h0) && !d[i];
    endfunction

    task automatic push_frame(input logic [15:0] v, input logic [3:0] d, input int first);
        exp_t       e;
        logic [3:0] a;
        for (int i = first; i < 4; i++) begin
            if (!digit_blanked(v, d, i)) begin
                a     = 4'b0001 << i;
                e.an  = ~a;
                e.seg = seg_ref[v[4*i +: 4]];
                e.dp  = ~d[i];
                sb_q.push_back(e);
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_frame();
        logic seen = 1'b0;
        for (int c = 0; c < 2 * FRAME && !seen; c++) begin
            @(negedge clk);
            seen = frame_start;
        end
        check("frame_start_seen", 32'(seen), 32'd1);
    endtask

    task automatic wait_drain();
        for (int c = 0; c < 3 * FRAME && sb_q.size() != 0; c++) @(negedge clk);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        mon_en = 1'b0;
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d);
        value = v;
        dp_in = d;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
    endtask

    // Scoreboard monitor: compare the first cycle of every digit drive window.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en && an !== 4'hF && an_prev === 4'hF) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_window_an", 32'(an), 32'hF);
            end else begin
                e = sb_q.pop_front();
                check("win_an",  32'(an),  32'(e.an));
                check("win_seg", 32'(seg), 32'(e.seg));
                check("win_dp",  32'(dp),  32'(e.dp));
            end
        end
        an_prev = an;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] exp_an;
        int         slot;
        logic [3:0] a;

        seg_ref = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        vecs = '{'{16'h12AF, 4'b0100}, '{16'hFFFF, 4'b1111}, '{16'h3456, 4'b0001},
                 '{16'h789B, 4'b1000}, '{16'hCDE0, 4'b1010}, '{16'h0070, 4'b0000}};

        clr = 1'b1; load = 1'b0; value = '0; dp_in = '0;
        cur_val = '0; cur_dp = '0;

        #1;
        check("rst_an",          32'(an),          32'hF);
        check("rst_seg",         32'(seg),         32'h7F);
        check("rst_dp",          32'(dp),          32'd1);
        check("rst_pending",     32'(pending),     32'd0);
        check("rst_frame_start", 32'(frame_start), 32'd0);

        idle(2);
        clr = 1'b0;

        // Free-running scan after reset: blank 2, drive 8, per digit, period 40.
        for (int k = 1; k <= FRAME + 5; k++) begin
            @(negedge clk);
            slot = (k / SLOT) % 4;
            a    = 4'b0001 << slot;
            exp_an = ((k % SLOT) < BLANK_CYC || (LZ_EN && slot > 0)) ? 4'hF : ~a;
            check("init_an", 32'(an), 32'(exp_an));
            check("init_frame_start", 32'(frame_start), 32'((k % FRAME) == 0));
            if (exp_an != 4'hF) check("init_seg", 32'(seg), 32'h40);
        end

        // Mid-frame loads: remainder of the frame keeps the old value, next frame shows the new.
        for (int i = 0; i < 6; i++) begin
            wait_frame();
            idle(5);
            push_frame(cur_val, cur_dp, 1);
            push_frame(vecs[i].value, vecs[i].dp, 0);
            mon_en = 1'b1;
            do_load(vecs[i].value, vecs[i].dp);
            check("vec_pending_set", 32'(pending), 32'd1);
            wait_drain();
            check("vec_pending_clr", 32'(pending), 32'd0);
            cur_val = vecs[i].value;
            cur_dp  = vecs[i].dp;
        end

        // Two loads in one frame: only the second is ever displayed.
        wait_frame();
        idle(5);
        push_frame(cur_val, cur_dp, 1);
        push_frame(16'h2222, 4'b0000, 0);
        mon_en = 1'b1;
        do_load(16'h1111, 4'b0000);
        idle(2);
        do_load(16'h2222, 4'b0000);
        check("dbl_pending_set", 32'(pending), 32'd1);
        wait_drain();
        check("dbl_pending_clr", 32'(pending), 32'd0);
        cur_val = 16'h2222; cur_dp = 4'b0000;

        // Load on the exact wrap edge bypasses the shadow.
        wait_frame();
        idle(FRAME - 1);
        push_frame(16'h0005, 4'b0000, 0);
        mon_en = 1'b1;
        do_load(16'h0005, 4'b0000);
        check("wrap_frame_start", 32'(frame_start), 32'd1);
        check("wrap_pending",     32'(pending),     32'd0);
        wait_drain();
        check("wrap_pending_after", 32'(pending), 32'd0);
        cur_val = 16'h0005; cur_dp = 4'b0000;

        // Clear pulsed during the digit-2 drive window.
        wait_frame();
        idle(2 * SLOT + 5);
        check("pre_clr_an", 32'(an), digit_blanked(cur_val, cur_dp, 2) ? 32'hF : 32'hB);
        #2 clr = 1'b1;
        #1;
        check("clr_an",          32'(an),          32'hF);
        check("clr_seg",         32'(seg),         32'h7F);
        check("clr_dp",          32'(dp),          32'd1);
        check("clr_frame_start", 32'(frame_start), 32'd0);
        idle(2);
        clr = 1'b0;
        push_frame(16'h0000, 4'b0000, 0);
        mon_en = 1'b1;
        wait_drain();
        check("post_clr_pending", 32'(pending), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
